// File: rtl/sc_fifo2_pkg.sv
// sc_fifo2_pkg: shared definitions for the sc_fifo2 single-clock FIFO.
// Holds the capacity helper used by the top to derive the full threshold.
// One RAM slot is always left unused so that a full FIFO and an empty FIFO
// are distinguishable from the pointers alone.
package sc_fifo2_pkg;

  // Usable capacity for a FIFO with 2**aw storage words.
  function automatic int fifo_cap(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/sc_fifo2_ram.sv
// sc_fifo2_ram: simple dual-port RAM, 2**AW x DW, for sc_fifo2.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset; clears only the read register
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata holds its value when low
//   raddr  - read address
//   rdata  - registered read data (one-cycle latency)
// The storage array itself is never reset.
module sc_fifo2_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The FIFO never reads the slot being written in the same cycle (the read
  // slot is occupied, the write slot is free), so no bypass is needed.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sc_fifo2.sv
// sc_fifo2: single-clock synchronous FIFO with registered read data.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   din       - write data
//   write     - write request (ignored while full)
//   dout      - read data, valid the cycle after an accepted read
//   read      - read request (ignored while empty)
//   wr_ptr    - current write address
//   rd_ptr    - current read address
//   data_cnt  - stored words, 0 .. 2**AW-1
//   full      - data_cnt == 2**AW-1
//   empty     - data_cnt == 0
//   overflow  - (SC_FIFO2_ERR_FLAGS_EN only) sticky, write while full
//   underflow - (SC_FIFO2_ERR_FLAGS_EN only) sticky, read while empty
// Optional feature macro: SC_FIFO2_ERR_FLAGS_EN.
module sc_fifo2
  import sc_fifo2_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          write,
  output logic [DW-1:0] dout,
  input  logic          read,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] data_cnt,
  output logic          full,
`ifdef SC_FIFO2_ERR_FLAGS_EN
  output logic          overflow,
  output logic          underflow,
`endif
  output logic          empty
);

  localparam logic [AW-1:0] CAP = AW'(fifo_cap(AW));

  logic wr_en, rd_en;

  assign full  = (data_cnt == CAP);
  assign empty = (data_cnt == '0);

  // Flags come from registered count, so these use pre-edge state.
  assign wr_en = write & ~full;
  assign rd_en = read & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   data_cnt <= data_cnt + 1'b1;
        2'b01:   data_cnt <= data_cnt - 1'b1;
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  sc_fifo2_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (dout)
  );

`ifdef SC_FIFO2_ERR_FLAGS_EN
  // Sticky: record any rejected request until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write & full)  overflow  <= 1'b1;
      if (read  & empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sc_fifo2.sv
module tb_sc_fifo2;
  localparam int DW = 9;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          write;
  logic          read;
  logic [DW-1:0] dout;
  logic [AW-1:0] wr_ptr, rd_ptr, data_cnt;
  logic          full, empty;
`ifdef SC_FIFO2_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];     // reference contents of the FIFO
  logic [DW-1:0] exp_q[$];  // words expected on dout, in order
  bit            rd_fire = 0;

  always #5 clk = ~clk;

  sc_fifo2 #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .write    (write),
    .dout     (dout),
    .read     (read),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .data_cnt (data_cnt),
    .full     (full),
`ifdef SC_FIFO2_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .empty    (empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one output word is due on the cycle after each accepted read.
  always @(negedge clk) begin
    if (rd_fire) begin
      rd_fire = 0;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dout: got 0x%0h with no expected word queued", dout);
      end else begin
        chk("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock with the given request; updates the reference FIFO.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wok, rok;
    wok = w && (mq.size() < 15);
    rok = r && (mq.size() > 0);
    write = w; read = r; din = d;
    @(posedge clk); #1;
    if (rok) begin
      exp_q.push_back(mq.pop_front());
      rd_fire = 1;
    end
    if (wok) mq.push_back(d);
    write = 0; read = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mq.delete(); exp_q.delete(); rd_fire = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; write = 0; read = 0; din = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_cnt", data_cnt, 0);
    chk("rst_dout", dout, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
`ifdef SC_FIFO2_ERR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`endif

    // 1: three writes then three reads
    step(1, 0, 9'h0A5);
    chk("t1_cnt1", data_cnt, 1);
    chk("t1_empty", empty, 0);
    step(1, 0, 9'h0C3);
    chk("t1_cnt2", data_cnt, 2);
    step(1, 0, 9'h137);
    chk("t1_cnt3", data_cnt, 3);
    repeat (3) step(0, 1, '0);
    @(negedge clk); #1;
    chk("t1_cnt0", data_cnt, 0);
    chk("t1_empty_end", empty, 1);

    // 3: read from empty leaves everything alone
    step(0, 1, '0);
    chk("t3_dout_hold", dout, 9'h137);
    chk("t3_rd_ptr", rd_ptr, 3);
    chk("t3_cnt", data_cnt, 0);
    chk("t3_empty", empty, 1);
`ifdef SC_FIFO2_ERR_FLAGS_EN
    chk("t3_unf", underflow, 1);
    step(0, 0, '0);
    chk("t3_unf_sticky", underflow, 1);
`endif

    // 2: fill to capacity, drop a 16th write, drain in order
    for (int i = 0; i < 15; i++) step(1, 0, 9'(i));
    chk("t2_full", full, 1);
    chk("t2_cnt", data_cnt, 15);
    chk("t2_wr_ptr", wr_ptr, 2);
    step(1, 0, 9'h1FF);
    chk("t2_wr_ptr_hold", wr_ptr, 2);
    chk("t2_cnt_hold", data_cnt, 15);
`ifdef SC_FIFO2_ERR_FLAGS_EN
    chk("t2_ovf", overflow, 1);
`endif
    repeat (15) step(0, 1, '0);
    @(negedge clk); #1;
    chk("t2_empty", empty, 1);
    chk("t2_rd_ptr", rd_ptr, 2);

    // 4: five stored, then 20 cycles of read+write (pointers wrap)
    for (int i = 0; i < 5; i++) step(1, 0, 9'(9'h100 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 9'(9'h110 + i));
      chk("t4_cnt", data_cnt, 5);
    end
    chk("t4_wr_ptr", wr_ptr, 11);
    chk("t4_rd_ptr", rd_ptr, 6);

    // 5: full plus simultaneous read/write
    for (int i = 0; i < 10; i++) step(1, 0, 9'(9'h150 + i));
    chk("t5_full", full, 1);
    step(1, 1, 9'h1AA);
    chk("t5_cnt", data_cnt, 14);
    chk("t5_full_off", full, 0);

    // 6: reset with 7 stored
    repeat (7) step(0, 1, '0);
    @(negedge clk); #1;
    chk("t6_cnt7", data_cnt, 7);
    do_reset();
    chk("t6_cnt", data_cnt, 0);
    chk("t6_empty", empty, 1);
    chk("t6_wr_ptr", wr_ptr, 0);
    chk("t6_rd_ptr", rd_ptr, 0);
    chk("t6_dout", dout, 0);
`ifdef SC_FIFO2_ERR_FLAGS_EN
    chk("t6_ovf_clr", overflow, 0);
    chk("t6_unf_clr", underflow, 0);
`endif
    step(1, 0, 9'h055);
    step(0, 1, '0);
    @(negedge clk); #1;
    chk("t6_dout_055", dout, 9'h055);
    chk("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
